dut_debounce_mc: RTL and testbench

//  Multi-channel input conditioner and successor to the single-bit dut_top path.

---
 rtl/dut_debounce_pkg.sv | 15 +
 rtl/dut_debounce_ch.sv | 97 +++++++++
 rtl/dut_debounce_mc.sv | 40 ++++
 tb/tb_dut_debounce_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_debounce_pkg.sv
// Shared defaults and helpers for the multi-channel debounce block.
package dut_debounce_pkg;

    localparam int CH_NUM_DEF   = 4;
    localparam int CNT_W_DEF    = 16;
    localparam int SYNC_STG_DEF = 2;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Rise/fall pulse pair for a committed change to the given new level.
    function automatic logic [1:0] edge_dir(input logic new_lvl);
        return {new_lvl, ~new_lvl};
    endfunction

endpackage

// File: rtl/dut_debounce_ch.sv
// One debounce channel: synchroniser chain, stability counter, debounced
// level register and registered rise/fall/glitch pulses.
module dut_debounce_ch
    import dut_debounce_pkg::*;
#(
    parameter int   CNT_W    = CNT_W_DEF,
    parameter int   SYNC_STG = SYNC_STG_DEF,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_data_in,
    input  logic [CNT_W-1:0] I_stable_cnt,
    input  logic             I_bypass,
    output logic             O_data_out,
    output logic             O_rise,
    output logic             O_fall,
    output logic             O_glitch
);

    logic [SYNC_STG-1:0] sync_q;
    logic [SYNC_STG-1:0] sync_d;
    logic                sync_lvl;
    logic                data_q;
    logic                data_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                rise_q;
    logic                rise_d;
    logic                fall_q;
    logic                fall_d;
    logic                glitch_q;
    logic                glitch_d;

    assign sync_lvl = sync_q[SYNC_STG-1];

    // Shift the raw input into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], I_data_in};
    end

    // Decide the next debounced level, counter value and pulses.
    always_comb begin
        data_d   = data_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        if (I_bypass) begin
            // Output follows the synchronised input; nothing pending.
            data_d = sync_lvl;
            cnt_d  = {CNT_W{1'b0}};
            if (sync_lvl != data_q) begin
                {rise_d, fall_d} = edge_dir(sync_lvl);
            end else begin
                {rise_d, fall_d} = 2'b00;
            end
        end else if (sync_lvl == data_q) begin
            // Input is back at the current level: any pending change aborted.
            cnt_d    = {CNT_W{1'b0}};
            glitch_d = (cnt_q != {CNT_W{1'b0}});
        end else if (cnt_q >= I_stable_cnt) begin
            // Held long enough; >= also covers a threshold lowered mid-count.
            data_d           = sync_lvl;
            cnt_d            = {CNT_W{1'b0}};
            {rise_d, fall_d} = edge_dir(sync_lvl);
        end else begin
            // Cannot wrap: the counter clears once it reaches the threshold.
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            sync_q   <= {SYNC_STG{RST_VAL}};
            data_q   <= RST_VAL;
            cnt_q    <= {CNT_W{1'b0}};
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign O_data_out = data_q;
    assign O_rise     = rise_q;
    assign O_fall     = fall_q;
    assign O_glitch   = glitch_q;

endmodule

// File: rtl/dut_debounce_mc.sv
// Multi-channel input conditioner: replicates one independent debounce
// channel per input bit, sharing the threshold and bypass controls.
module dut_debounce_mc
    import dut_debounce_pkg::*;
#(
    parameter int   CH_NUM   = CH_NUM_DEF,
    parameter int   CNT_W    = CNT_W_DEF,
    parameter int   SYNC_STG = SYNC_STG_DEF,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [CH_NUM-1:0] I_data_in,
    input  logic [CNT_W-1:0]  I_stable_cnt,
    input  logic              I_bypass,
    output logic [CH_NUM-1:0] O_data_out,
    output logic [CH_NUM-1:0] O_rise,
    output logic [CH_NUM-1:0] O_fall,
    output logic [CH_NUM-1:0] O_glitch
);

    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
        dut_debounce_ch #(
            .CNT_W    (CNT_W),
            .SYNC_STG (SYNC_STG),
            .RST_VAL  (RST_VAL)
        ) u_ch (
            .I_clk        (I_clk),
            .I_rst        (I_rst),
            .I_data_in    (I_data_in[ch]),
            .I_stable_cnt (I_stable_cnt),
            .I_bypass     (I_bypass),
            .O_data_out   (O_data_out[ch]),
            .O_rise       (O_rise[ch]),
            .O_fall       (O_fall[ch]),
            .O_glitch     (O_glitch[ch])
        );
    end

endmodule

// File: tb/tb_dut_debounce_mc.sv
// Self-checking bench for dut_debounce_mc with a behavioural per-channel model.
module tb_dut_debounce_mc;

    localparam int CH  = 4;
    localparam int CW  = 16;
    localparam int STG = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] din;
    logic [CW-1:0] ncnt;
    logic          byp;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] glitch;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_tot = 0;
    int fall_tot = 0;
    int gl_tot   = 0;

    // Model state: sampled-input history, current level, length of the
    // current run of edges on which the synchronised input differed.
    bit m_hist [CH][STG];
    bit m_lvl  [CH];
    int m_run  [CH];
    bit m_r    [CH];
    bit m_f    [CH];
    bit m_g    [CH];
    bit m_valid = 1'b0;

    dut_debounce_mc #(
        .CH_NUM   (CH),
        .CNT_W    (CW),
        .SYNC_STG (STG),
        .RST_VAL  (1'b0)
    ) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_data_in    (din),
        .I_stable_cnt (ncnt),
        .I_bypass     (byp),
        .O_data_out   (dout),
        .O_rise       (rise),
        .O_fall       (fall),
        .O_glitch     (glitch)
    );

    always #10 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int n;
        bit s;
        n = int'(ncnt);
        for (int ch = 0; ch < CH; ch++) begin
            m_r[ch] = 1'b0;
            m_f[ch] = 1'b0;
            m_g[ch] = 1'b0;
            if (!rst) begin
                for (int k = 0; k < STG; k++) m_hist[ch][k] = 1'b0;
                m_lvl[ch] = 1'b0;
                m_run[ch] = 0;
            end else begin
                s = m_hist[ch][STG-1];
                if (byp) begin
                    if (s != m_lvl[ch]) begin
                        m_r[ch] = s;
                        m_f[ch] = !s;
                    end
                    m_lvl[ch] = s;
                    m_run[ch] = 0;
                end else if (s == m_lvl[ch]) begin
                    m_g[ch] = (m_run[ch] > 0);
                    m_run[ch] = 0;
                end else if (m_run[ch] + 1 > n) begin
                    // This is differing edge number run+1; N+1 of them commit.
                    m_lvl[ch] = s;
                    m_r[ch] = s;
                    m_f[ch] = !s;
                    m_run[ch] = 0;
                end else begin
                    m_run[ch] = m_run[ch] + 1;
                end
                for (int k = STG - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
                m_hist[ch][0] = din[ch];
            end
        end
        if (!rst) m_valid = 1'b1;
    endtask

    function automatic logic [CH-1:0] pack(input bit v [CH]);
        logic [CH-1:0] r;
        for (int ch = 0; ch < CH; ch++) r[ch] = v[ch];
        return r;
    endfunction

    // Model update on each edge, then compare all outputs shortly after.
    always begin
        @(posedge clk);
        cyc++;
        model_step();
        #2;
        if (m_valid) begin
            check("model_dout",   32'(dout),   32'(pack(m_lvl)));
            check("model_rise",   32'(rise),   32'(pack(m_r)));
            check("model_fall",   32'(fall),   32'(pack(m_f)));
            check("model_glitch", 32'(glitch), 32'(pack(m_g)));
        end
        rise_tot += $countones(rise);
        fall_tot += $countones(fall);
        gl_tot   += $countones(glitch);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int r0;
        int f0;
        int g0;
        rst  = 1'b0;
        din  = 4'hF;
        ncnt = 16'd10;
        byp  = 1'b0;

        // Reset held with all inputs high: everything stays at zero.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("reset_dout",   32'(dout), 32'h0);
            check("reset_pulses", 32'(rise | fall | glitch), 32'h0);
        end
        rst = 1'b1;
        din = 4'h0;
        tick(5);

        // Clean edge on ch0 with N=10: commit on the 13th edge.
        din[0] = 1'b1;
        r0 = rise_tot;
        tick(12);
        check("clean_before", 32'(dout[0]), 32'h0);
        tick(1);
        check("clean_commit", 32'(dout[0]), 32'h1);
        check("clean_rise",   32'(rise[0]), 32'h1);
        tick(37);
        check("clean_rise_once", 32'(rise_tot - r0), 32'd1);

        // Short pulse on ch1: aborted change, one glitch, no rise.
        r0 = rise_tot;
        g0 = gl_tot;
        din[1] = 1'b1;
        tick(5);
        din[1] = 1'b0;
        tick(20);
        check("glitch_dout",  32'(dout[1]), 32'h0);
        check("glitch_count", 32'(gl_tot - g0), 32'd1);
        check("glitch_norise", 32'(rise_tot - r0), 32'd0);

        // N=0: ch2 toggling every 4 clocks, 3-clock latency.
        ncnt = 16'd0;
        din[2] = 1'b1;
        tick(2);
        check("n0_before", 32'(dout[2]), 32'h0);
        tick(1);
        check("n0_commit", 32'(dout[2]), 32'h1);
        check("n0_rise",   32'(rise[2]), 32'h1);
        tick(1);
        for (int t = 0; t < 7; t++) begin
            din[2] = ~din[2];
            tick(4);
        end
        tick(6);

        // N=0xFFFF on ch3: 65535 differing edges are not enough, 65536 are.
        ncnt = 16'hFFFF;
        din[3] = 1'b1;
        tick(65537);
        check("nmax_65535", 32'(dout[3]), 32'h0);
        tick(1);
        check("nmax_65536", 32'(dout[3]), 32'h1);
        check("nmax_rise",  32'(rise[3]), 32'h1);
        tick(2);

        // Bypass with all channels rising together.
        byp = 1'b1;
        din = 4'h0;
        tick(5);
        check("byp_low", 32'(dout), 32'h0);
        din = 4'hF;
        tick(2);
        check("byp_before", 32'(dout), 32'h0);
        tick(1);
        check("byp_commit", 32'(dout), 32'hF);
        check("byp_rise",   32'(rise), 32'hF);
        tick(3);

        // Reset in the middle of a filtered count: no pulses for the dropped change.
        din = 4'h0;
        tick(4);
        byp  = 1'b0;
        ncnt = 16'd10;
        din  = 4'hF;
        tick(6);
        r0 = rise_tot;
        f0 = fall_tot;
        g0 = gl_tot;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        din = 4'h0;
        tick(20);
        check("rstmid_dout",   32'(dout), 32'h0);
        check("rstmid_pulses", 32'((rise_tot - r0) + (fall_tot - f0) + (gl_tot - g0)), 32'd0);

        // Randomised traffic: thresholds, bypass and resets changing on the fly.
        ncnt = 16'd3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) ncnt = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) byp = ~byp;
            rst = ($urandom_range(0, 399) != 0);
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range(0, 5) == 0) din[ch] = ~din[ch];
            end
        end
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
